// File: rtl/core_key_pio.sv
// core_key_pio: Avalon-MM key/switch input port.
// Pins are synchronized, optionally debounced, edge-detected into sticky
// EDGE_CAPTURE bits, and combined with IRQ_MASK into a level interrupt.
// Optional feature: define CORE_KEY_PIO_DEBOUNCE_EN to add a shared stable-hold
// debounce filter (DEBOUNCE_CYCLES must then be >= 2).
// Register map: 0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C).
module core_key_pio #(
  parameter int WIDTH           = 8,
  parameter int CAPTURE_EDGE    = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] dly_q;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;

  // Only the low WIDTH bits of writedata carry register content.
  logic unused_wd;
  assign unused_wd = ^writedata;

  // Two-flop synchronizer on the raw pins, plus the delayed filtered copy used for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      dly_q <= '0;
    end else begin
      s1_q  <= in_port;
      s2_q  <= s1_q;
      dly_q <= filt;
    end
  end

`ifdef CORE_KEY_PIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  // Change detection and the count register each cost one clock, so loading at
  // a count of DEBOUNCE_CYCLES-2 means s2 has held for DEBOUNCE_CYCLES clocks
  // at the load edge (DATA latency 2+DEBOUNCE_CYCLES from the pin).
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] s2_prev_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_change;

  // Shared stable-hold counter: restart on any bit change, saturate, load filter once stable
  always_comb begin
    s2_change = (s2_q != s2_prev_q);
    cnt_d     = cnt_q;
    filt_d    = filt_q;
    if (s2_change) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CNT_LOAD) filt_d = s2_q;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_prev_q <= '0;
      cnt_q     <= '0;
      filt_q    <= '0;
    end else begin
      s2_prev_q <= s2_q;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  localparam logic [31:0] DEB_CFG = 32'(DEBOUNCE_CYCLES);
  logic unused_cfg;
  assign unused_cfg = ^DEB_CFG;

  assign filt = s2_q;
`endif

  // Per-bit edge detection on the filtered value, selected by CAPTURE_EDGE
  always_comb begin
    case (CAPTURE_EDGE)
      0:       edge_det = filt & ~dly_q;
      1:       edge_det = ~filt & dly_q;
      default: edge_det = filt ^ dly_q;
    endcase
  end

  // Register write decode; a new edge overrides a same-cycle clear
  always_comb begin
    wr_en      = chipselect & ~write_n;
    irq_mask_d = irq_mask_q;
    cap_clr    = '0;
    if (wr_en && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) cap_clr = writedata[WIDTH-1:0];
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
  end

  // Mask and capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  // Zero-wait-state read mux, independent of chipselect
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = filt;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_cap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_core_key_pio.sv
// Bench for core_key_pio: two instances (falling-edge and both-edge capture)
// share the bus and pins; checks are queued and compared at the falling clock edge.
module tb_core_key_pio;
   localparam int W = 8;
`ifdef CORE_KEY_PIO_DEBOUNCE_EN
   localparam int DEB = 16;
   localparam int LAT = 2 + DEB;
`else
   localparam int DEB = 16;
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address, address2;
   logic          chipselect, write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata, readdata2;
   logic [W-1:0]  in_port;
   logic          irq, irq2;
   logic          done = 1'b0;

   always #5 clk = ~clk;

   core_key_pio #(.WIDTH(W), .CAPTURE_EDGE(1), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .in_port(in_port), .irq(irq)
   );

   core_key_pio #(.WIDTH(W), .CAPTURE_EDGE(2), .DEBOUNCE_CYCLES(DEB)) dut2 (
      .clk(clk), .reset(reset), .address(address2), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata2),
      .in_port(in_port), .irq(irq2)
   );

   string       sb_name[$];
   int          sb_sel[$];
   logic [31:0] sb_rd[$];
   logic        sb_irq[$];
   int          total = 0;
   int          bad = 0;

   string       mon_nm;
   int          mon_sel;
   logic [31:0] mon_er, mon_ar;
   logic        mon_ei, mon_ai;

   // Monitor: compare every queued expectation against the live outputs
   always @(negedge clk) begin
      while (sb_name.size() > 0) begin
         mon_nm  = sb_name.pop_front();
         mon_sel = sb_sel.pop_front();
         mon_er  = sb_rd.pop_front();
         mon_ei  = sb_irq.pop_front();
         mon_ar  = (mon_sel == 0) ? readdata : readdata2;
         mon_ai  = (mon_sel == 0) ? irq : irq2;
         total++;
         if (mon_ar !== mon_er || mon_ai !== mon_ei) begin
            bad++;
            $display("FAIL %s: dut%0d readdata=%h irq=%b, expected readdata=%h irq=%b",
                     mon_nm, mon_sel, mon_ar, mon_ai, mon_er, mon_ei);
         end
      end
   end

   initial begin
      #200000;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout: stimulus did not complete, total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   task automatic tick();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int sel, input string nm, input logic [1:0] a,
                      input logic [31:0] e, input logic ei);
      if (sel == 0) address = a;
      else address2 = a;
      sb_name.push_back(nm);
      sb_sel.push_back(sel);
      sb_rd.push_back(e);
      sb_irq.push_back(ei);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      address2   = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      address2   = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 8'h80;
      tick();
      tick();
      total++;
      if (readdata !== 32'h0 || readdata2 !== 32'h0 || irq !== 1'b0 || irq2 !== 1'b0) begin
         bad++;
         $display("FAIL rst_direct: readdata=%h readdata2=%h irq=%b irq2=%b, expected all 0",
                  readdata, readdata2, irq, irq2);
      end
      chk(0, "rst_data", 2'd0, 32'h0, 1'b0);
      chk(1, "rst_rsvd", 2'd1, 32'h0, 1'b0);
      tick();

      // Pin held high across reset release looks like a rising edge
      reset = 1'b0;
      repeat (LAT + 1) tick();
      chk(0, "por_data", 2'd0, 32'h80, 1'b0);
      chk(1, "por_cap_both", 2'd3, 32'h80, 1'b0);
      tick();
      chk(0, "por_cap_fall", 2'd3, 32'h00, 1'b0);
      chk(1, "rsvd_read", 2'd1, 32'h0, 1'b0);
      tick();

      // Writes to DATA and reserved are ignored
      wr(2'd1, 32'hFFFF_FFFF);
      wr(2'd0, 32'h0000_0000);
      chk(0, "wr_rsvd", 2'd1, 32'h0, 1'b0);
      chk(1, "wr_data_ro", 2'd0, 32'h80, 1'b0);
      tick();

      wr(2'd3, 32'hFF);
      in_port = 8'hFF;
      repeat (LAT + 2) tick();
      wr(2'd3, 32'hFF);
      chk(0, "cap_clear", 2'd3, 32'h0, 1'b0);
      chk(1, "cap_clear2", 2'd3, 32'h0, 1'b0);
      tick();

      // 0xFF -> 0xFE: DATA after LAT clocks, capture one clock later
      in_port = 8'hFE;
      for (int k = 0; k <= LAT + 1; k++) begin
         chk(0, "fall_data", 2'd0, (k >= LAT) ? 32'hFE : 32'hFF, 1'b0);
         chk(1, "fall_cap", 2'd3, (k >= LAT + 1) ? 32'h01 : 32'h00, 1'b0);
         tick();
      end
      chk(0, "fall_cap1", 2'd3, 32'h01, 1'b0);
      chk(1, "mask0_irq", 2'd2, 32'h00, 1'b0);
      tick();

      wr(2'd2, 32'h01);
      chk(0, "mask_irq_on", 2'd2, 32'h01, 1'b1);
      chk(1, "mask_irq_on2", 2'd3, 32'h01, 1'b1);
      tick();
      wr(2'd3, 32'h01);
      chk(0, "w1c_irq_off", 2'd3, 32'h00, 1'b0);
      chk(1, "w1c_irq_off2", 2'd3, 32'h00, 1'b0);
      tick();

      // Clear of bit 2 lands on the same edge that captures its falling edge
      in_port = 8'hFA;
      repeat (LAT) tick();
      wr(2'd3, 32'h04);
      chk(0, "set_wins", 2'd3, 32'h04, 1'b0);
      chk(1, "set_wins2", 2'd3, 32'h04, 1'b0);
      tick();

      wr(2'd2, 32'h04);
      chk(0, "mask_b2_irq", 2'd3, 32'h04, 1'b1);
      chk(1, "mask_b2_rd", 2'd2, 32'h04, 1'b1);
      tick();
      wr(2'd2, 32'h00);
      chk(0, "unmask_cap_kept", 2'd3, 32'h04, 1'b0);
      chk(1, "unmask_rd", 2'd2, 32'h00, 1'b0);
      tick();

      // Fill all capture bits and the mask, then reset
      in_port = 8'hFF;
      repeat (LAT + 2) tick();
      in_port = 8'h00;
      repeat (LAT + 2) tick();
      wr(2'd2, 32'hFF);
      chk(0, "all_cap", 2'd3, 32'hFF, 1'b1);
      chk(1, "all_cap2", 2'd3, 32'hFF, 1'b1);
      tick();
      reset = 1'b1;
      chk(0, "rst_cap", 2'd3, 32'h0, 1'b0);
      chk(1, "rst_mask", 2'd2, 32'h0, 1'b0);
      tick();
      chk(0, "rst_data2", 2'd0, 32'h0, 1'b0);
      chk(1, "rst_rsvd2", 2'd1, 32'h0, 1'b0);
      tick();
      reset = 1'b0;
      repeat (3) tick();

`ifdef CORE_KEY_PIO_DEBOUNCE_EN
      // Bit 0 bounces with 5-clock periods for 40 clocks, then settles at 0
      in_port = 8'h01;
      repeat (LAT + 3) tick();
      wr(2'd3, 32'hFF);
      for (int t = 0; t <= 65; t++) begin
         in_port = (t < 40 && ((t / 5) % 2) == 1) ? 8'h01 : 8'h00;
         chk(0, "deb_data", 2'd0, (t >= 40 + LAT) ? 32'h00 : 32'h01, 1'b0);
         chk(1, "deb_cap", 2'd3, (t >= 41 + LAT) ? 32'h01 : 32'h00, 1'b0);
         tick();
      end
      chk(0, "deb_one_cap", 2'd3, 32'h01, 1'b0);
      tick();
`endif

      tick();
      done = 1'b1;
      if (bad == 0) $display("PASS test done: total=%0d bad=%0d", total, bad);
      else $display("FAIL test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_key_pio.md
CORE_KEY_PIO -- requirements
Module: core_key_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of input pins sampled.
REQ-002 Parameter CAPTURE_EDGE, default 1: edge that sets a capture bit; 0 rising, 1 falling, 2 either.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: stable-hold length; used only when the debounce filter is compiled in.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  Avalon-MM slave select.
REQ-008 write_n  input  1  Avalon-MM write strobe, active low.
REQ-009 writedata  input  32  Avalon-MM write data.
REQ-010 readdata  output  32  Avalon-MM read data, zero wait states.
REQ-011 in_port  input  WIDTH  asynchronous external pins (keys/switches).
REQ-012 irq  output  1  level interrupt request, active high.

Function
REQ-013 Register map SHALL be: 0 DATA (RO, filtered pin value), 1 reserved (reads 0, writes ignored), 2 IRQ_MASK (RW, WIDTH bits), 3 EDGE_CAPTURE (read; write-1-to-clear).
REQ-014 readdata SHALL be combinational in address; unused upper bits zero; chipselect does not gate readdata.
REQ-015 A write occurs on a clock edge where chipselect=1 and write_n=0; writes to address 0 or 1 have no effect.
REQ-016 in_port SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-017 Without the debounce filter, filtered value = s2; DATA reflects a pin change 2 clocks after the sampling edge.
REQ-018 Edge detection SHALL compare filtered value with its one-clock-delayed copy, per bit, per CAPTURE_EDGE.
REQ-019 A detected edge SHALL set the matching EDGE_CAPTURE bit on the next clock edge; bits stay set until cleared.
REQ-020 Write to address 3 SHALL clear each EDGE_CAPTURE bit whose writedata bit is 1; bits with writedata 0 are untouched.
REQ-021 Simultaneous set and clear of the same bit in one cycle: set wins, bit reads 1 afterwards.
REQ-022 irq = OR over bits of (EDGE_CAPTURE AND IRQ_MASK), combinational; deasserts the cycle after the last enabled bit clears.
REQ-023 IRQ_MASK changes SHALL affect irq immediately (combinationally) without altering EDGE_CAPTURE.

Reset
REQ-024 While reset=1: s1, s2, filtered value, delayed copy, debounce counter, IRQ_MASK, EDGE_CAPTURE all 0; irq=0; readdata for address 0 reads 0.
REQ-025 A pin held high across reset release SHALL appear as a rising edge after release (captured only if CAPTURE_EDGE is 0 or 2).
REQ-026 Reset asserted mid-debounce SHALL discard the count; no capture bit survives reset.

Configuration
REQ-027 Macro CORE_KEY_PIO_DEBOUNCE_EN defined: a single shared counter restarts at 0 whenever s2 differs from its previous value; filtered value loads s2 when s2 has been constant for DEBOUNCE_CYCLES consecutive clocks; counter saturates; DATA latency becomes 2+DEBOUNCE_CYCLES clocks.
REQ-028 Macro undefined: no counter logic synthesized; filtered value = s2 exactly per REQ-017; DEBOUNCE_CYCLES ignored.

Verification
REQ-029 No debounce, CAPTURE_EDGE=1: in_port 0xFF->0xFE -> DATA reads 0xFE after 2 clocks, EDGE_CAPTURE reads 0x01 after 3 clocks, irq=0 while IRQ_MASK=0.
REQ-030 IRQ_MASK=0x01 written with EDGE_CAPTURE=0x01 -> irq=1 same cycle; write 0x01 to address 3 -> EDGE_CAPTURE=0, irq=0 next cycle.
REQ-031 Clear write of 0x04 to address 3 in the same cycle a falling edge on bit 2 is being set -> EDGE_CAPTURE bit 2 reads 1 afterwards.
REQ-032 Debounce on, DEBOUNCE_CYCLES=16: bit 0 toggles every 5 clocks for 40 clocks then holds 0 -> DATA bit 0 unchanged until 16 clocks of stability, exactly one capture.
REQ-033 CAPTURE_EDGE=2, in_port held 0x80 across reset release -> EDGE_CAPTURE reads 0x80; CAPTURE_EDGE=1 same stimulus -> reads 0x00.
REQ-034 Reset asserted with EDGE_CAPTURE=0xFF, IRQ_MASK=0xFF, irq=1 -> all read 0, irq=0 immediately; reads at address 1 return 0 throughout.
